police_dispatch: RTL and testbench

Dispatcher that sits on the caller side of the police car's call/return interface. It counts corpse reports, waits a fixed response delay measured in video frames, then raises `on_call` to bring the police car in. It keeps the car on scene while reports remain outstanding, then raises `police_back` to send the car away and returns to idle. It also drives a frames-remaining value for the HUD.

---
 rtl/police_dispatch.sv | 116 +++++++++++
 tb/tb_police_dispatch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/police_dispatch.sv
// police_dispatch: counts corpse reports, waits DELAY_FRAMES frame edges, then calls the
// police car in; keeps it on scene while reports remain, then sends it back. Rev 1.0
`default_nettype none

module police_dispatch #(
   parameter int DELAY_FRAMES = 120,
   parameter int MAX_PENDING  = 7
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       corpse_seen,
   input  logic       complete,
   input  logic       police_out,
   input  logic       reset_corpse,
   output logic       on_call,
   output logic       police_back,
   output logic [2:0] pending,
   output logic [7:0] frames_left
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COUNTDOWN  = 2'd1,
      DISPATCHED = 2'd2,
      RETURNING  = 2'd3
   } state_t;

   localparam logic [2:0] MAX_PEND = 3'(MAX_PENDING);
   localparam logic [7:0] DELAY    = 8'(DELAY_FRAMES);

   state_t     state, state_next;
   logic       frame_d;
   logic       fedge;
   logic       dec_req;
   logic [2:0] pend_next;
   logic [7:0] frames_next;

   assign fedge   = frame_clk & ~frame_d;
   assign dec_req = complete && (state == DISPATCHED);

   always_comb begin
      pend_next = pending;
      if (reset_corpse) begin
         pend_next = 3'd0;
      end else if (corpse_seen && dec_req) begin
         pend_next = pending;
      end else if (corpse_seen) begin
         if (pending < MAX_PEND) pend_next = pending + 3'd1;
      end else if (dec_req) begin
         if (pending != 3'd0) pend_next = pending - 3'd1;
      end
   end

   always_comb begin
      state_next  = state;
      frames_next = frames_left;
      case (state)
         IDLE: begin
            if ((pending != 3'd0 || corpse_seen) && !reset_corpse) begin
               state_next  = COUNTDOWN;
               frames_next = DELAY;
            end
         end
         COUNTDOWN: begin
            // Cancelling wins over a frame edge arriving in the same cycle.
            if (reset_corpse) begin
               state_next  = IDLE;
               frames_next = 8'd0;
            end else if (fedge) begin
               if (frames_left == 8'd1) begin
                  state_next  = DISPATCHED;
                  frames_next = 8'd0;
               end else begin
                  frames_next = frames_left - 8'd1;
               end
            end
         end
         DISPATCHED: begin
            if (reset_corpse) begin
               state_next = RETURNING;
            end else if (complete && pend_next == 3'd0) begin
               state_next = RETURNING;
            end
         end
         RETURNING: begin
            if (!police_out) state_next = IDLE;
         end
         default: begin
            state_next  = IDLE;
            frames_next = 8'd0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         frame_d     <= 1'b0;
         pending     <= 3'd0;
         frames_left <= 8'd0;
         on_call     <= 1'b0;
         police_back <= 1'b0;
      end else begin
         state       <= state_next;
         frame_d     <= frame_clk;
         pending     <= pend_next;
         frames_left <= frames_next;
         on_call     <= (state_next == DISPATCHED);
         police_back <= (state_next == RETURNING);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_police_dispatch.sv
// tb_police_dispatch: directed self-checking bench for police_dispatch (DELAY_FRAMES=4). Rev 1.0
`default_nettype none

module tb_police_dispatch;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       corpse_seen = 1'b0;
   logic       complete = 1'b0;
   logic       police_out = 1'b1;
   logic       reset_corpse = 1'b0;
   logic       on_call;
   logic       police_back;
   logic [2:0] pending;
   logic [7:0] frames_left;

   int n_checks = 0;
   int n_fail   = 0;

   police_dispatch #(.DELAY_FRAMES(4), .MAX_PENDING(7)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .corpse_seen  (corpse_seen),
      .complete     (complete),
      .police_out   (police_out),
      .reset_corpse (reset_corpse),
      .on_call      (on_call),
      .police_back  (police_back),
      .pending      (pending),
      .frames_left  (frames_left)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_corpse();
      corpse_seen = 1'b1;
      step();
      corpse_seen = 1'b0;
   endtask

   task automatic pulse_complete();
      complete = 1'b1;
      step();
      complete = 1'b0;
   endtask

   task automatic pulse_clear();
      reset_corpse = 1'b1;
      step();
      reset_corpse = 1'b0;
   endtask

   task automatic frame_edge();
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      n_checks++;
      if ({on_call, police_back, pending, frames_left} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got on_call=%b back=%b pending=%0d frames=%0d, need all 0",
                  on_call, police_back, pending, frames_left);
      end
      Reset = 1'b0;
      step();
      n_checks++;
      if ({on_call, police_back, pending, frames_left} !== 13'd0) begin
         n_fail++;
         $display("FAIL after_reset_idle: got on_call=%b back=%b pending=%0d frames=%0d, need all 0",
                  on_call, police_back, pending, frames_left);
      end
   endtask

   task automatic test_basic();
      pulse_corpse();
      n_checks++;
      if (frames_left !== 8'd4 || pending !== 3'd1 || on_call !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_start: frames=%0d pending=%0d on_call=%b, need 4 1 0",
                  frames_left, pending, on_call);
      end
      // first edge: hold frame_clk high for several cycles, must count once
      frame_clk = 1'b1;
      step();
      step();
      step();
      n_checks++;
      if (frames_left !== 8'd3) begin
         n_fail++;
         $display("FAIL basic_held_high: frames=%0d, need 3", frames_left);
      end
      frame_clk = 1'b0;
      step();
      for (int i = 2; i <= 4; i++) begin
         frame_clk = 1'b1;
         step();
         n_checks++;
         if (frames_left !== 8'(4 - i) || on_call !== (i == 4)) begin
            n_fail++;
            $display("FAIL basic_edge%0d: frames=%0d on_call=%b, need %0d %b",
                     i, frames_left, on_call, 4 - i, (i == 4));
         end
         frame_clk = 1'b0;
         step();
      end
      n_checks++;
      if (on_call !== 1'b1 || pending !== 3'd1 || police_back !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_dispatched: on_call=%b pending=%0d back=%b, need 1 1 0",
                  on_call, pending, police_back);
      end
      pulse_complete();
      n_checks++;
      if (on_call !== 1'b0 || police_back !== 1'b1 || pending !== 3'd0) begin
         n_fail++;
         $display("FAIL basic_return: on_call=%b back=%b pending=%0d, need 0 1 0",
                  on_call, police_back, pending);
      end
      step();
      n_checks++;
      if (police_back !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_wait_car: back=%b, need 1", police_back);
      end
      police_out = 1'b0;
      step();
      police_out = 1'b1;
      n_checks++;
      if (on_call !== 1'b0 || police_back !== 1'b0 || frames_left !== 8'd0) begin
         n_fail++;
         $display("FAIL basic_idle: on_call=%b back=%b frames=%0d, need 0 0 0",
                  on_call, police_back, frames_left);
      end
   endtask

   task automatic test_multi();
      pulse_corpse();
      frame_edge();
      pulse_corpse();
      pulse_complete();
      pulse_corpse();
      n_checks++;
      if (frames_left !== 8'd3 || pending !== 3'd3) begin
         n_fail++;
         $display("FAIL multi_no_reload: frames=%0d pending=%0d, need 3 3", frames_left, pending);
      end
      frame_edge();
      frame_edge();
      frame_edge();
      n_checks++;
      if (on_call !== 1'b1 || pending !== 3'd3) begin
         n_fail++;
         $display("FAIL multi_dispatch: on_call=%b pending=%0d, need 1 3", on_call, pending);
      end
      for (int i = 1; i <= 3; i++) begin
         pulse_complete();
         n_checks++;
         if (pending !== 3'(3 - i) || on_call !== (i < 3) || police_back !== (i == 3)) begin
            n_fail++;
            $display("FAIL multi_complete%0d: pending=%0d on_call=%b back=%b, need %0d %b %b",
                     i, pending, on_call, police_back, 3 - i, (i < 3), (i == 3));
         end
      end
      police_out = 1'b0;
      step();
      police_out = 1'b1;
      n_checks++;
      if (on_call !== 1'b0 || police_back !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_idle: on_call=%b back=%b, need 0 0", on_call, police_back);
      end
   endtask

   task automatic test_saturation();
      corpse_seen = 1'b1;
      repeat (9) step();
      corpse_seen = 1'b0;
      n_checks++;
      if (pending !== 3'd7 || frames_left !== 8'd4) begin
         n_fail++;
         $display("FAIL sat_hold: pending=%0d frames=%0d, need 7 4", pending, frames_left);
      end
      repeat (4) frame_edge();
      corpse_seen = 1'b1;
      complete = 1'b1;
      step();
      corpse_seen = 1'b0;
      complete = 1'b0;
      n_checks++;
      if (pending !== 3'd7 || on_call !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_simultaneous: pending=%0d on_call=%b, need 7 1", pending, on_call);
      end
      pulse_clear();
      n_checks++;
      if (pending !== 3'd0 || on_call !== 1'b0 || police_back !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_clear_dispatched: pending=%0d on_call=%b back=%b, need 0 0 1",
                  pending, on_call, police_back);
      end
      police_out = 1'b0;
      step();
      police_out = 1'b1;
   endtask

   task automatic test_cancel();
      pulse_corpse();
      frame_edge();
      frame_edge();
      n_checks++;
      if (frames_left !== 8'd2) begin
         n_fail++;
         $display("FAIL cancel_setup: frames=%0d, need 2", frames_left);
      end
      pulse_clear();
      n_checks++;
      if (frames_left !== 8'd0 || pending !== 3'd0 || on_call !== 1'b0 || police_back !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel: frames=%0d pending=%0d on_call=%b back=%b, need 0 0 0 0",
                  frames_left, pending, on_call, police_back);
      end
      repeat (3) frame_edge();
      n_checks++;
      if (on_call !== 1'b0 || frames_left !== 8'd0) begin
         n_fail++;
         $display("FAIL cancel_stays_idle: on_call=%b frames=%0d, need 0 0", on_call, frames_left);
      end
      corpse_seen = 1'b1;
      reset_corpse = 1'b1;
      step();
      corpse_seen = 1'b0;
      reset_corpse = 1'b0;
      n_checks++;
      if (pending !== 3'd0 || frames_left !== 8'd0) begin
         n_fail++;
         $display("FAIL clear_beats_report: pending=%0d frames=%0d, need 0 0", pending, frames_left);
      end
   endtask

   task automatic test_rereport();
      pulse_corpse();
      repeat (4) frame_edge();
      pulse_complete();
      pulse_corpse();
      n_checks++;
      if (police_back !== 1'b1 || pending !== 3'd1 || frames_left !== 8'd0) begin
         n_fail++;
         $display("FAIL rereport_returning: back=%b pending=%0d frames=%0d, need 1 1 0",
                  police_back, pending, frames_left);
      end
      police_out = 1'b0;
      step();
      police_out = 1'b1;
      n_checks++;
      if (police_back !== 1'b0 || on_call !== 1'b0 || frames_left !== 8'd0 || pending !== 3'd1) begin
         n_fail++;
         $display("FAIL rereport_idle: back=%b on_call=%b frames=%0d pending=%0d, need 0 0 0 1",
                  police_back, on_call, frames_left, pending);
      end
      step();
      n_checks++;
      if (frames_left !== 8'd4 || pending !== 3'd1) begin
         n_fail++;
         $display("FAIL rereport_countdown: frames=%0d pending=%0d, need 4 1", frames_left, pending);
      end
      pulse_clear();
   endtask

   task automatic test_async_reset();
      pulse_corpse();
      pulse_corpse();
      repeat (4) frame_edge();
      n_checks++;
      if (on_call !== 1'b1 || pending !== 3'd2) begin
         n_fail++;
         $display("FAIL async_setup: on_call=%b pending=%0d, need 1 2", on_call, pending);
      end
      @(negedge Clk);
      #1 Reset = 1'b1;
      #1;
      n_checks++;
      if ({on_call, police_back, pending, frames_left} !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset: on_call=%b back=%b pending=%0d frames=%0d, need all 0",
                  on_call, police_back, pending, frames_left);
      end
      step();
      Reset = 1'b0;
      step();
      n_checks++;
      if (on_call !== 1'b0 || pending !== 3'd0) begin
         n_fail++;
         $display("FAIL async_after: on_call=%b pending=%0d, need 0 0", on_call, pending);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_saturation();
      test_cancel();
      test_rereport();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
